acc_requant: RTL and testbench
==============================

# acc_requant

Downstream output stage for the MAC datapath. It captures each 32-bit accumulator result on a one-cycle valid pulse, which is driven from the controller's done. It then adds a bias, applies a rounding arithmetic right shift, optionally applies ReLU, and saturates to signed 8 bits. Results are buffered in an 8-entry FIFO and presented on a valid/ready stream, ready for an output BRAM writer or the next layer's x-BRAM loader.

## Interface
- ACC_WIDTH, 32, accumulator/bias width (signed)
- OUT_WIDTH, 8, output width (signed)
- SHIFT_WIDTH, 5, shift amount width
- DEPTH, 8, output FIFO entries (power of two)
- clk_i  in  1  clock, all state on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- clear_i  in  1  synchronous flush of pipeline, FIFO and flags
- acc_valid_i  in  1  accumulator result valid (single-cycle pulse)
- acc_i  in  ACC_WIDTH  signed accumulator
- acc_ready_o  out  1  a pulse on acc_valid_i will be accepted this cycle
- bias_i  in  ACC_WIDTH  signed bias, sampled with acc_i
- shift_i  in  SHIFT_WIDTH  right-shift amount 0..31, sampled with acc_i
- relu_en_i  in  1  clamp negatives to 0, sampled with acc_i
- out_valid_o  out  1  FIFO head valid
- out_data_o  out  OUT_WIDTH  FIFO head value
- out_ready_i  in  1  consumer accepts head when out_valid_o=1
- count_o  out  log2(DEPTH)+1  FIFO occupancy
- sat_o  out  1  sticky: some result was clamped to the OUT range
- drop_o  out  1  sticky: acc_valid_i arrived with acc_ready_o=0

## Operation
- Reset value of every output is 0. Pipeline valids, FIFO pointers and count are 0. acc_ready_o is 1 once rstn_i is high, because it is combinational from count and in-flight.
- Accept condition: acc_valid_i & acc_ready_o. Accepted inputs are never lost.
- S1 (registered): sum = sext(acc_i) + sext(bias_i), 33 bits. shift_i and relu_en_i are carried along with the sum.
  - Config changes never affect entries already in flight.
- S2 (registered): 34-bit rounding shift.
  - shift=0: r = sum.
  - Otherwise: r = (sum + 2^(shift-1)) >>> shift. This rounds half toward +inf.
- S3 (write into FIFO): apply ReLU if enabled (r<0 → 0), then clamp to [-128, 127].
  - If the clamp changed the value, set sat_o.
  - The ReLU zeroing alone does not set sat_o.
- Credit rule: acc_ready_o = (count + S1 valid + S2 valid) < DEPTH. With this rule the FIFO never overflows.
- Drop: acc_valid_i with acc_ready_o=0 discards the input and sets drop_o. No other state changes.
- Pop: out_valid_o & out_ready_i. The FIFO is first-in first-out and out_data_o holds stable while it is not popped.
- Simultaneous write and pop: the count is unchanged. A write into an empty FIFO with no pop makes out_valid_o=1 on the following cycle. There is no fall-through.
- clear_i has priority over all other activity in the same cycle. It zeroes S1/S2 valids, pointers, count, sat_o and drop_o. An input arriving in the same cycle is discarded, and drop_o is not set.
- rstn_i low mid-operation has the same effect as clear_i, applied immediately and asynchronously.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.

## Timing
- Latency: the input is sampled at edge k. The FIFO write happens at edge k+2. out_valid_o is high from edge k+2 when the FIFO was empty: 3 cycles from pulse to visible output.
- Throughput: 1 result per cycle when out_ready_i=1 continuously.
- acc_ready_o, out_valid_o, out_data_o and count_o come from registers. The only combinational path is the credit compare; there is no input-to-output comb path.
- Max accepted back-to-back with out_ready_i=0: DEPTH. acc_ready_o drops in the cycle after the DEPTH-th accept.

## Structure
- `requant_pkg` holds ACC_WIDTH, OUT_WIDTH, OUT_MAX=127, OUT_MIN=-128, and the function sat_round(sum, shift, relu) returning {value, sat}.
- Sub-module `req_fifo` is a synchronous DEPTH×OUT_WIDTH FIFO with push, pop, clear, count and registered head. It is reusable by the future output-BRAM writer.
- The top file holds the S1/S2 pipeline, the credit logic and the sticky flags.

## Test plan
- Basic path: acc=100, bias=-4, shift=2, relu=0 → out_data_o=24. out_valid_o=1 three cycles after the pulse. sat_o=0.
- Rounding and ReLU: acc=-10, bias=0, shift=2 → -2. The same input with relu=1 → 0, with sat_o staying 0. acc=6, shift=2 → 2 (1.5 rounds up).
- Saturation: acc=40000, shift=4 → 127 with sat_o=1. acc=-40000, shift=4 → -128. shift=0, acc=127 → 127 with no sat.
- Backpressure: out_ready_i=0 and 10 back-to-back pulses with values 1..10 → count_o=8, acc_ready_o=0 and drop_o=1. Draining then yields exactly 1..8 in order.
- Concurrent push/pop: count=4 with a write and a pop on the same edge → count stays 4 and ordering is intact. Draining to empty → out_valid_o=0 with no stale data.
- Flush/reset: 3 entries stored, 2 in flight and sat_o=1, then clear_i for one cycle → next cycle count_o=0, out_valid_o=0 and flags 0, with no late write. Repeat the same check using an asynchronous rstn_i pulse between edges.

Source files
------------

// File: rtl/acc_requant_pkg.sv
// Shared widths, pipeline structs and the bias/round/ReLU/saturate arithmetic for the MAC output stage.
// The math is split into two helpers so the pipeline can register between the shift and the clamp.
package requant_pkg;

  localparam int ACC_WIDTH   = 32;
  localparam int OUT_WIDTH   = 8;
  localparam int SHIFT_WIDTH = 5;
  localparam int DEPTH       = 8;
  localparam int CNT_WIDTH   = $clog2(DEPTH) + 1;
  localparam int SUM_WIDTH   = ACC_WIDTH + 1;
  localparam int RND_WIDTH   = ACC_WIDTH + 2;
  localparam int OUT_MAX     = 127;
  localparam int OUT_MIN     = -128;

  typedef logic signed [SUM_WIDTH-1:0] sum_t;
  typedef logic signed [RND_WIDTH-1:0] rnd_t;
  typedef logic signed [OUT_WIDTH-1:0] out_t;

  typedef struct packed {
    sum_t                   sum;
    logic [SHIFT_WIDTH-1:0] shift;
    logic                   relu;
  } s1_t;

  typedef struct packed {
    out_t value;
    logic sat;
  } sat_t;

  // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
  function automatic rnd_t round_shift(input sum_t sum, input logic [SHIFT_WIDTH-1:0] shift);
    rnd_t r;
    rnd_t half;
    r    = rnd_t'(sum);
    half = rnd_t'(1) << (shift - 1'b1);
    if (shift != '0) begin
      r = (r + half) >>> shift;
    end
    return r;
  endfunction

  function automatic sat_t clamp_relu(input rnd_t r, input logic relu);
    sat_t res;
    rnd_t v;
    v = (relu && r[RND_WIDTH-1]) ? '0 : r;
    if (v > rnd_t'(OUT_MAX)) begin
      res.value = out_t'(OUT_MAX);
      res.sat   = 1'b1;
    end else if (v < rnd_t'(OUT_MIN)) begin
      res.value = out_t'(OUT_MIN);
      res.sat   = 1'b1;
    end else begin
      res.value = v[OUT_WIDTH-1:0];
      res.sat   = 1'b0;
    end
    return res;
  endfunction

  function automatic sat_t sat_round(input sum_t sum, input logic [SHIFT_WIDTH-1:0] shift,
                                     input logic relu);
    return clamp_relu(round_shift(sum, shift), relu);
  endfunction

endpackage

// File: rtl/acc_requant_if.sv
// Accumulator-in / int8-out stream bundle: pulse-with-credit on the input side, valid/ready on the output side.
interface acc_requant_if;
  import requant_pkg::*;

  logic                   acc_valid;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   bias;
  logic [SHIFT_WIDTH-1:0] shift;
  logic                   relu_en;
  logic                   acc_ready;
  logic                   out_valid;
  logic [OUT_WIDTH-1:0]   out_data;
  logic                   out_ready;

  modport master (
    output acc_valid, acc, bias, shift, relu_en, out_ready,
    input  acc_ready, out_valid, out_data
  );

  modport slave (
    input  acc_valid, acc, bias, shift, relu_en, out_ready,
    output acc_ready, out_valid, out_data
  );

endinterface

// File: rtl/acc_requant_req_fifo.sv
// Synchronous DEPTH x WIDTH FIFO, head read from registers, no fall-through (push visible next cycle).
// Pop is ignored when empty; push must be credit-guarded by the caller; clear beats push/pop.
module req_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic             do_pop;

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    do_pop = pop_i & vld_q;
    if (clear_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) begin
        mem_d[wr_q] = data_i;
        wr_d        = wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_d = rd_q + 1'b1;
      end
      cnt_d = cnt_q + CW'(push_i) - CW'(do_pop);
    end
    vld_d = (cnt_d != '0);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      vld_q <= vld_d;
    end
  end

  assign valid_o = vld_q;
  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/acc_requant.sv
// MAC output stage: bias add (S1), rounding shift (S2), ReLU/saturate into an 8-deep FIFO; 3 cycles pulse-to-output.
// Input side is credit-based (acc_ready_o counts FIFO plus in-flight); pulses seen without credit are dropped and flagged.
module acc_requant
  import requant_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clear_i,
  acc_requant_if.slave         bus,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 sat_o,
  output logic                 drop_o
);

  localparam int CW1 = CNT_WIDTH + 1;

  s1_t            s1_d, s1_q;
  logic           s1_vld_d, s1_vld_q;
  rnd_t           rnd_d, rnd_q;
  logic           relu2_d, relu2_q;
  logic           s2_vld_d, s2_vld_q;
  logic           sat_d, sat_q;
  logic           drop_d, drop_q;
  logic [CW1-1:0] credit;
  logic           accept;
  logic           push;
  logic           pop;
  sat_t           s3;

  // Anything already in S1/S2 is guaranteed a FIFO slot, so it counts against the credit.
  assign credit        = {1'b0, count_o} + CW1'(s1_vld_q) + CW1'(s2_vld_q);
  assign bus.acc_ready = rstn_i & (credit < CW1'(DEPTH));
  assign pop           = bus.out_valid & bus.out_ready;

  always_comb begin
    accept   = bus.acc_valid & bus.acc_ready & ~clear_i;
    s1_vld_d = accept;
    s1_d     = s1_q;
    if (accept) begin
      s1_d.sum   = sum_t'($signed(bus.acc)) + sum_t'($signed(bus.bias));
      s1_d.shift = bus.shift;
      s1_d.relu  = bus.relu_en;
    end
    s2_vld_d = s1_vld_q & ~clear_i;
    rnd_d    = round_shift(s1_q.sum, s1_q.shift);
    relu2_d  = s1_q.relu;
    push     = s2_vld_q & ~clear_i;
    s3       = clamp_relu(rnd_q, relu2_q);
    sat_d    = clear_i ? 1'b0 : (sat_q | (push & s3.sat));
    drop_d   = clear_i ? 1'b0 : (drop_q | (bus.acc_valid & ~bus.acc_ready));
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
      rnd_q    <= '0;
      relu2_q  <= 1'b0;
      s2_vld_q <= 1'b0;
      sat_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      s1_q     <= s1_d;
      s1_vld_q <= s1_vld_d;
      rnd_q    <= rnd_d;
      relu2_q  <= relu2_d;
      s2_vld_q <= s2_vld_d;
      sat_q    <= sat_d;
      drop_q   <= drop_d;
    end
  end

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (OUT_WIDTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear_i (clear_i),
    .push_i  (push),
    .data_i  (s3.value),
    .pop_i   (pop),
    .valid_o (bus.out_valid),
    .data_o  (bus.out_data),
    .count_o (count_o)
  );

  assign sat_o  = sat_q;
  assign drop_o = drop_q;

endmodule

// File: tb/tb_acc_requant.sv
// Directed bench for acc_requant: arithmetic, latency, credit/drop, ordering, clear and async reset.
module tb_acc_requant;
  import requant_pkg::*;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 clear;
  logic [CNT_WIDTH-1:0] count;
  logic                 sat;
  logic                 drop;
  int                   n_checks = 0;
  int                   n_fail   = 0;

  always #5 clk = ~clk;

  acc_requant_if dif ();

  acc_requant dut (
    .clk_i   (clk),
    .rstn_i  (rstn),
    .clear_i (clear),
    .bus     (dif.slave),
    .count_o (count),
    .sat_o   (sat),
    .drop_o  (drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int a, input int b, input int sh, input bit r);
    dif.acc       = a;
    dif.bias      = b;
    dif.shift     = SHIFT_WIDTH'(sh);
    dif.relu_en   = r;
    dif.acc_valid = 1'b1;
  endtask

  task automatic send(input int a, input int b, input int sh, input bit r);
    drive(a, b, sh, r);
    tick();
    dif.acc_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!dif.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_vld"}, 32'(dif.out_valid), 32'd1);
    chk(tag, 32'(dif.out_data), 32'(exp));
    dif.out_ready = 1'b1;
    tick();
    dif.out_ready = 1'b0;
  endtask

  initial begin
    rstn          = 1'b0;
    clear         = 1'b0;
    dif.acc_valid = 1'b0;
    dif.acc       = '0;
    dif.bias      = '0;
    dif.shift     = '0;
    dif.relu_en   = 1'b0;
    dif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(dif.out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_acc_ready", 32'(dif.acc_ready), 32'd0);
    rstn = 1'b1;
    #1;
    chk("ready_after_reset", 32'(dif.acc_ready), 32'd1);
    tick();

    // 100-4=96, (96+2)>>2 = 24; visible on the third edge after the pulse
    send(100, -4, 2, 0);
    chk("lat_k", 32'(dif.out_valid), 32'd0);
    tick();
    chk("lat_k1", 32'(dif.out_valid), 32'd0);
    tick();
    chk("lat_k2", 32'(dif.out_valid), 32'd1);
    pop_check("basic", 8'd24);
    chk("basic_sat", 32'(sat), 32'd0);

    send(-10, 0, 2, 0);
    pop_check("round_neg", 8'hFE);
    send(-10, 0, 2, 1);
    pop_check("relu", 8'h00);
    chk("relu_nosat", 32'(sat), 32'd0);
    send(6, 0, 2, 0);
    pop_check("round_half", 8'd2);

    send(40000, 0, 4, 0);
    pop_check("sat_pos", 8'd127);
    chk("sat_pos_flag", 32'(sat), 32'd1);
    send(-40000, 0, 4, 0);
    pop_check("sat_neg", 8'h80);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_sat", 32'(sat), 32'd0);
    send(127, 0, 0, 0);
    pop_check("shift0", 8'd127);
    chk("shift0_nosat", 32'(sat), 32'd0);

    // ten back-to-back pulses against a stalled consumer
    for (int i = 1; i <= 10; i++) begin
      drive(i, 0, 0, 0);
      tick();
      if (i == 7) chk("ready_after7", 32'(dif.acc_ready), 32'd1);
      if (i == 8) chk("ready_after8", 32'(dif.acc_ready), 32'd0);
    end
    dif.acc_valid = 1'b0;
    tick();
    tick();
    chk("bp_count", 32'(count), 32'd8);
    chk("bp_ready", 32'(dif.acc_ready), 32'd0);
    chk("bp_drop", 32'(drop), 32'd1);
    for (int i = 1; i <= 8; i++) begin
      pop_check("bp_drain", 8'(i));
    end
    chk("bp_empty_vld", 32'(dif.out_valid), 32'd0);
    chk("bp_empty_cnt", 32'(count), 32'd0);
    chk("bp_ready_back", 32'(dif.acc_ready), 32'd1);

    // write and pop on the same edge at count 4
    for (int i = 11; i <= 14; i++) begin
      send(i, 0, 0, 0);
    end
    tick();
    tick();
    chk("cc_pre_count", 32'(count), 32'd4);
    send(15, 0, 0, 0);
    tick();
    dif.out_ready = 1'b1;
    tick();
    dif.out_ready = 1'b0;
    chk("cc_count", 32'(count), 32'd4);
    chk("cc_head", 32'(dif.out_data), 32'd12);
    for (int i = 12; i <= 15; i++) begin
      pop_check("cc_drain", 8'(i));
    end
    chk("cc_empty_vld", 32'(dif.out_valid), 32'd0);
    chk("cc_empty_cnt", 32'(count), 32'd0);

    // synchronous clear with 3 stored and 2 in flight
    send(300, 0, 0, 0);
    send(21, 0, 0, 0);
    send(22, 0, 0, 0);
    tick();
    tick();
    chk("fl_pre_count", 32'(count), 32'd3);
    chk("fl_pre_sat", 32'(sat), 32'd1);
    drive(23, 0, 0, 0);
    tick();
    drive(24, 0, 0, 0);
    tick();
    drive(25, 0, 0, 0);
    clear = 1'b1;
    tick();
    clear         = 1'b0;
    dif.acc_valid = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_vld", 32'(dif.out_valid), 32'd0);
    chk("fl_sat", 32'(sat), 32'd0);
    chk("fl_drop", 32'(drop), 32'd0);
    repeat (3) tick();
    chk("fl_late_count", 32'(count), 32'd0);
    chk("fl_late_vld", 32'(dif.out_valid), 32'd0);

    // same scenario, asynchronous reset pulse between edges
    send(300, 0, 0, 0);
    send(21, 0, 0, 0);
    send(22, 0, 0, 0);
    tick();
    tick();
    chk("ar_pre_count", 32'(count), 32'd3);
    drive(23, 0, 0, 0);
    tick();
    drive(24, 0, 0, 0);
    tick();
    dif.acc_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("ar_count", 32'(count), 32'd0);
    chk("ar_vld", 32'(dif.out_valid), 32'd0);
    chk("ar_sat", 32'(sat), 32'd0);
    #2 rstn = 1'b1;
    repeat (3) tick();
    chk("ar_late_count", 32'(count), 32'd0);
    chk("ar_late_vld", 32'(dif.out_valid), 32'd0);
    send(100, -4, 2, 0);
    pop_check("post_reset", 8'd24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
